// File: rtl/dcache_wt.sv
// Direct-mapped write-through, no-write-allocate data cache: read hits return the same cycle, misses refill WORDS words, writes stall until i_mem_ack.
// Build with DCACHE_STATS_EN defined to add saturating hit/miss counters.
module dcache_wt #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 30,
    parameter int SETS       = 16,
    parameter int WORDS      = 4
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    input  logic                    i_we,
    input  logic                    i_re,
    input  logic [DATA_WIDTH/8-1:0] i_be,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic                    i_flush,
    output logic [DATA_WIDTH-1:0]   o_rdata,
    output logic [ADDR_WIDTH-1:0]   o_mem_addr,
    output logic                    o_mem_we,
    output logic                    o_mem_re,
    output logic [DATA_WIDTH/8-1:0] o_mem_be,
    output logic [DATA_WIDTH-1:0]   o_mem_wdata,
    input  logic [DATA_WIDTH-1:0]   i_mem_rdata,
    input  logic                    i_mem_ack,
    output logic                    o_busy,
    output logic                    o_hit
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]             o_hit_count,
    output logic [31:0]             o_miss_count
`endif
);
    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_WIDTH - OFF_W - IDX_W;
    localparam int BE_W  = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

    state_t                  r_state;
    logic [SETS-1:0]         r_valid;
    logic [TAG_W-1:0]        r_tag  [SETS];
    logic [DATA_WIDTH-1:0]   r_data [SETS][WORDS];
    logic                    r_flush_pend;
    logic [ADDR_WIDTH-1:0]   r_mem_addr;
    logic                    r_mem_we;
    logic                    r_mem_re;
    logic [BE_W-1:0]         r_mem_be;
    logic [DATA_WIDTH-1:0]   r_mem_wdata;

    logic [OFF_W-1:0]        w_off;
    logic [IDX_W-1:0]        w_idx;
    logic [TAG_W-1:0]        w_tag;
    logic [OFF_W-1:0]        w_rf_off;
    logic [IDX_W-1:0]        w_rf_idx;
    logic [TAG_W-1:0]        w_rf_tag;
    logic                    w_match;
    logic                    w_idle;
    logic                    w_flush;
    logic                    w_rd_req;
    logic                    w_go_write;
    logic                    w_go_refill;
    logic                    w_rd_accept;
    logic                    w_refill_done;

    assign w_off    = i_addr[OFF_W-1:0];
    assign w_idx    = i_addr[OFF_W +: IDX_W];
    assign w_tag    = i_addr[ADDR_WIDTH-1 -: TAG_W];
    // Refill bookkeeping follows the registered memory address, not the request.
    assign w_rf_off = r_mem_addr[OFF_W-1:0];
    assign w_rf_idx = r_mem_addr[OFF_W +: IDX_W];
    assign w_rf_tag = r_mem_addr[ADDR_WIDTH-1 -: TAG_W];

    assign w_match       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_idle        = (r_state == IDLE);
    assign w_flush       = i_flush || r_flush_pend;
    assign w_rd_req      = i_re && !i_we;
    assign w_go_write    = w_idle && !w_flush && i_we;
    assign w_go_refill   = w_idle && !w_flush && w_rd_req && !w_match;
    assign w_rd_accept   = w_idle && !w_flush && w_rd_req && w_match;
    assign w_refill_done = (r_state == REFILL) && i_mem_ack && (&w_rf_off);

    assign o_mem_addr  = r_mem_addr;
    assign o_mem_we    = r_mem_we;
    assign o_mem_re    = r_mem_re;
    assign o_mem_be    = r_mem_be;
    assign o_mem_wdata = r_mem_wdata;

    always_comb begin
        o_hit   = !i_reset && w_idle && (i_re || i_we) && w_match;
        o_rdata = '0;
        if (!i_reset && w_rd_accept) begin
            o_rdata = r_data[w_idx][w_off];
        end
        o_busy = 1'b0;
        if (!i_reset) begin
            case (r_state)
                IDLE:    o_busy = w_flush || i_we || (w_rd_req && !w_match);
                REFILL:  o_busy = 1'b1;
                WRITE:   o_busy = !i_mem_ack;
                default: o_busy = 1'b0;
            endcase
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_valid      <= '0;
            r_flush_pend <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_we     <= 1'b0;
            r_mem_re     <= 1'b0;
            r_mem_be     <= '0;
            r_mem_wdata  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_flush) begin
                        r_valid      <= '0;
                        r_flush_pend <= 1'b0;
                    end else if (w_go_write) begin
                        r_state     <= WRITE;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= i_addr;
                        r_mem_be    <= i_be;
                        r_mem_wdata <= i_wdata;
                    end else if (w_go_refill) begin
                        // Line is stale while it is being overwritten word by word.
                        r_state        <= REFILL;
                        r_mem_re       <= 1'b1;
                        r_mem_addr     <= {w_tag, w_idx, {OFF_W{1'b0}}};
                        r_valid[w_idx] <= 1'b0;
                    end
                end
                REFILL: begin
                    if (i_flush) r_flush_pend <= 1'b1;
                    if (i_mem_ack) begin
                        r_mem_addr <= r_mem_addr + ADDR_WIDTH'(1);
                        if (w_refill_done) begin
                            r_valid[w_rf_idx] <= 1'b1;
                            r_state           <= IDLE;
                            r_mem_re          <= 1'b0;
                            r_mem_addr        <= '0;
                        end
                    end
                end
                WRITE: begin
                    if (i_flush) r_flush_pend <= 1'b1;
                    if (i_mem_ack) begin
                        r_state     <= IDLE;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= '0;
                        r_mem_be    <= '0;
                        r_mem_wdata <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (r_state == REFILL && i_mem_ack) begin
            r_data[w_rf_idx][w_rf_off] <= i_mem_rdata;
            if (&w_rf_off) r_tag[w_rf_idx] <= w_rf_tag;
        end
        if (r_state == WRITE && i_mem_ack && w_match) begin
            for (int b = 0; b < BE_W; b++) begin
                if (i_be[b]) r_data[w_idx][w_off][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;
    logic        r_after_refill;

    // A read replayed after its own refill is accepted as a hit but is not counted as one.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_hit_count    <= '0;
            r_miss_count   <= '0;
            r_after_refill <= 1'b0;
        end else begin
            if (w_go_refill && r_miss_count != '1) r_miss_count <= r_miss_count + 32'd1;
            if (w_rd_accept && !r_after_refill && r_hit_count != '1) r_hit_count <= r_hit_count + 32'd1;
            if (w_refill_done) r_after_refill <= 1'b1;
            else if (w_idle && !w_flush) r_after_refill <= 1'b0;
        end
    end

    assign o_hit_count  = r_hit_count;
    assign o_miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_dcache_wt.sv
// Bench for dcache_wt: directed scenarios plus randomized reads/writes against a line-residency and memory model.
module tb_dcache_wt;
    localparam int DW = 32;
    localparam int AW = 30;
    localparam int NSETS = 16;
    localparam int NWORDS = 4;

    logic          i_clock;
    logic          i_reset;
    logic [AW-1:0] i_addr;
    logic          i_we;
    logic          i_re;
    logic [3:0]    i_be;
    logic [DW-1:0] i_wdata;
    logic          i_flush;
    logic [DW-1:0] o_rdata;
    logic [AW-1:0] o_mem_addr;
    logic          o_mem_we;
    logic          o_mem_re;
    logic [3:0]    o_mem_be;
    logic [DW-1:0] o_mem_wdata;
    logic [DW-1:0] i_mem_rdata;
    logic          i_mem_ack;
    logic          o_busy;
    logic          o_hit;
`ifdef DCACHE_STATS_EN
    logic [31:0]   o_hit_count;
    logic [31:0]   o_miss_count;
`endif

    dcache_wt #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SETS(NSETS), .WORDS(NWORDS)) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_addr(i_addr), .i_we(i_we), .i_re(i_re),
        .i_be(i_be), .i_wdata(i_wdata), .i_flush(i_flush), .o_rdata(o_rdata),
        .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we), .o_mem_re(o_mem_re), .o_mem_be(o_mem_be),
        .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata), .i_mem_ack(i_mem_ack),
        .o_busy(o_busy), .o_hit(o_hit)
`ifdef DCACHE_STATS_EN
        , .o_hit_count(o_hit_count), .o_miss_count(o_miss_count)
`endif
    );

    int checks = 0;
    int errors = 0;
    bit ack_all = 1'b1;
    int exp_hits = 0;
    int exp_miss = 0;

    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    logic [DW-1:0] sim_mem [logic [AW-1:0]];
    logic [27:0]   model_line [NSETS];
    bit            model_v [NSETS];

    initial begin
        i_clock = 1'b0;
        forever #5 i_clock = ~i_clock;
    end

    function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
        return 32'(a) * 32'h9E3779B1 + 32'h01234567;
    endfunction

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    function automatic logic [DW-1:0] sim_rd(input logic [AW-1:0] a);
        return sim_mem.exists(a) ? sim_mem[a] : dflt(a);
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                            input logic [3:0] be);
        logic [DW-1:0] r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Memory responder: commits acked writes, presents data for the current address.
    always @(posedge i_clock) begin
        if (o_mem_we === 1'b1 && i_mem_ack === 1'b1)
            sim_mem[o_mem_addr] = merge(sim_rd(o_mem_addr), o_mem_wdata, o_mem_be);
        #1;
        i_mem_ack   = ack_all ? 1'b1 : ($urandom_range(0, 2) != 0);
        i_mem_rdata = sim_rd(o_mem_addr);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic model_clear();
        for (int s = 0; s < NSETS; s++) model_v[s] = 1'b0;
    endtask

    // Read request held until accepted; extra = refills forced by a flush during the refill.
    task automatic do_read(input logic [AW-1:0] a, input int extra);
        logic [27:0]   ln;
        logic [AW-1:0] exp_addr;
        int idx, busy_n, ack_n, refills;
        bit exp_hit;
        ln = 28'(a >> 2);
        idx = int'(ln % 16);
        exp_hit = model_v[idx] && model_line[idx] == ln;
        refills = exp_hit ? 0 : 1 + extra;
        i_addr = a; i_re = 1'b1; i_we = 1'b0;
        @(negedge i_clock);
        checks++;
        if (o_hit !== exp_hit) begin
            errors++; $display("FAIL rd_first_hit addr=%h got %b want %b", a, o_hit, exp_hit);
        end
        busy_n = 0; ack_n = 0;
        while (o_busy === 1'b1 && busy_n < 100) begin
            busy_n++;
            checks++;
            if (o_mem_we !== 1'b0) begin
                errors++; $display("FAIL rd_no_write addr=%h o_mem_we=%b want 0", a, o_mem_we);
            end
            if (o_mem_re === 1'b1 && i_mem_ack === 1'b1) begin
                exp_addr = {ln, 2'b00} + AW'(ack_n % NWORDS);
                checks++;
                if (o_mem_addr !== exp_addr) begin
                    errors++; $display("FAIL refill_addr got %h want %h", o_mem_addr, exp_addr);
                end
                ack_n++;
            end
            @(negedge i_clock);
        end
        checks++;
        if (busy_n >= 100) begin
            errors++; $display("FAIL rd_timeout addr=%h busy still %b after 100 cycles", a, o_busy);
        end else if (o_hit !== 1'b1 || o_rdata !== ref_rd(a)) begin
            errors++; $display("FAIL rd_accept addr=%h hit=%b data=%h want hit=1 data=%h", a, o_hit, o_rdata, ref_rd(a));
        end
        checks++;
        if (ack_n != refills * NWORDS) begin
            errors++; $display("FAIL rd_acks addr=%h got %0d want %0d", a, ack_n, refills * NWORDS);
        end
        if (ack_all) begin
            checks++;
            if (busy_n != refills * (NWORDS + 1) + extra) begin
                errors++; $display("FAIL rd_busy_cycles addr=%h got %0d want %0d", a, busy_n, refills * (NWORDS + 1) + extra);
            end
        end
        if (refills > 0) begin
            model_v[idx] = 1'b1; model_line[idx] = ln; exp_miss += refills;
        end else begin
            exp_hits++;
        end
        @(posedge i_clock); #1;
        i_re = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [3:0] be, input logic [DW-1:0] d, input bit both);
        logic [27:0] ln;
        int idx, n;
        bit exp_hit, done;
        ln = 28'(a >> 2);
        idx = int'(ln % 16);
        exp_hit = model_v[idx] && model_line[idx] == ln;
        i_addr = a; i_we = 1'b1; i_re = both; i_be = be; i_wdata = d;
        @(negedge i_clock);
        checks++;
        if (o_hit !== exp_hit || o_busy !== 1'b1 || o_mem_we !== 1'b0) begin
            errors++; $display("FAIL wr_first addr=%h hit=%b busy=%b mem_we=%b want %b 1 0", a, o_hit, o_busy, o_mem_we, exp_hit);
        end
        n = 0; done = 1'b0;
        do begin
            @(negedge i_clock);
            n++;
            checks++;
            if (o_mem_we !== 1'b1 || o_mem_re !== 1'b0 || o_mem_addr !== a || o_mem_be !== be || o_mem_wdata !== d) begin
                errors++; $display("FAIL wr_strobe we=%b re=%b addr=%h be=%b data=%h want 1 0 %h %b %h",
                                   o_mem_we, o_mem_re, o_mem_addr, o_mem_be, o_mem_wdata, a, be, d);
            end
            checks++;
            if (o_busy !== !i_mem_ack) begin
                errors++; $display("FAIL wr_busy got %b want %b (ack=%b)", o_busy, !i_mem_ack, i_mem_ack);
            end
            done = (i_mem_ack === 1'b1);
        end while (!done && n < 100);
        if (!done) begin
            checks++; errors++; $display("FAIL wr_timeout addr=%h no ack in 100 cycles", a);
        end
        ref_mem[a] = merge(ref_rd(a), d, be);
        @(posedge i_clock); #1;
        i_we = 1'b0; i_re = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_re = 1'b1; i_addr = 30'h10; i_we = 1'b0; i_flush = 1'b0;
        i_be = 4'hF; i_wdata = 32'hDEADBEEF; i_mem_ack = 1'b1; i_mem_rdata = '0;
        #1;
        checks++;
        if (o_busy !== 1'b0 || o_hit !== 1'b0 || o_mem_re !== 1'b0 || o_mem_we !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl busy=%b hit=%b re=%b we=%b want 0 0 0 0", o_busy, o_hit, o_mem_re, o_mem_we);
        end
        checks++;
        if (o_mem_addr !== '0 || o_mem_be !== '0 || o_mem_wdata !== '0 || o_rdata !== '0) begin
            errors++; $display("FAIL reset_data addr=%h be=%b wdata=%h rdata=%h want zeros", o_mem_addr, o_mem_be, o_mem_wdata, o_rdata);
        end
`ifdef DCACHE_STATS_EN
        checks++;
        if (o_hit_count !== 32'd0 || o_miss_count !== 32'd0) begin
            errors++; $display("FAIL reset_stats hits=%0d misses=%0d want 0 0", o_hit_count, o_miss_count);
        end
`endif
        i_re = 1'b0;
        repeat (3) @(posedge i_clock);
        @(negedge i_clock);
        i_reset = 1'b0;
        model_clear(); exp_hits = 0; exp_miss = 0;
        @(posedge i_clock); #1;
    endtask

    task automatic test_directed();
        ref_mem[30'h12] = 32'h12345678;
        sim_mem[30'h12] = 32'h12345678;
        do_read(30'h10, 0);
        do_read(30'h12, 0);
`ifdef DCACHE_STATS_EN
        checks++;
        if (o_miss_count !== 32'd1 || o_hit_count !== 32'd1) begin
            errors++; $display("FAIL stats_basic hits=%0d misses=%0d want 1 1", o_hit_count, o_miss_count);
        end
`endif
        do_write(30'h12, 4'b0011, 32'hAAAA5555, 1'b0);
        do_read(30'h12, 0);
        checks++;
        if (ref_rd(30'h12) !== 32'h12345555) begin
            errors++; $display("FAIL partial_write model got %h want 12345555", ref_rd(30'h12));
        end
        do_write(30'h100, 4'hF, 32'hCAFEF00D, 1'b0);
        do_read(30'h100, 0);
        do_read(30'h50, 0);
        do_read(30'h10, 0);
    endtask

    task automatic test_flush();
        i_flush = 1'b1; i_re = 1'b1; i_addr = 30'h10;
        @(negedge i_clock);
        checks++;
        if (o_busy !== 1'b1 || o_mem_re !== 1'b0) begin
            errors++; $display("FAIL flush_idle busy=%b re=%b want 1 0", o_busy, o_mem_re);
        end
        @(posedge i_clock); #1;
        i_flush = 1'b0; i_re = 1'b0;
        model_clear();
        do_read(30'h10, 0);
        fork
            do_read(30'h20, 1);
            begin
                repeat (2) @(posedge i_clock);
                #1 i_flush = 1'b1;
                @(posedge i_clock);
                #1 i_flush = 1'b0;
            end
        join
        model_clear(); model_v[8] = 1'b1; model_line[8] = 28'h8;
    endtask

    task automatic test_reset_mid_refill();
        do_read(30'h50, 0);
        i_re = 1'b1; i_addr = 30'h10;
        repeat (3) @(posedge i_clock);
        #3;
        i_reset = 1'b1;
        #1;
        checks++;
        if (o_mem_re !== 1'b0 || o_busy !== 1'b0 || o_hit !== 1'b0 || o_mem_addr !== '0 || o_rdata !== '0) begin
            errors++; $display("FAIL reset_mid re=%b busy=%b hit=%b addr=%h rdata=%h want zeros", o_mem_re, o_busy, o_hit, o_mem_addr, o_rdata);
        end
        i_re = 1'b0;
        @(negedge i_clock);
        i_reset = 1'b0;
        model_clear(); exp_hits = 0; exp_miss = 0;
        @(posedge i_clock); #1;
        do_read(30'h10, 0);
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        for (int k = 0; k < 300; k++) begin
            ack_all = ($urandom_range(0, 1) == 1);
            a = AW'($urandom_range(0, 255));
            if ($urandom_range(0, 9) < 6) do_read(a, 0);
            else do_write(a, 4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 9) == 0));
        end
        ack_all = 1'b1;
`ifdef DCACHE_STATS_EN
        checks++;
        if (o_hit_count !== 32'(exp_hits) || o_miss_count !== 32'(exp_miss)) begin
            errors++; $display("FAIL stats_random hits=%0d misses=%0d want %0d %0d", o_hit_count, o_miss_count, exp_hits, exp_miss);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_directed();
        test_flush();
        test_reset_mid_refill();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
